// File: rtl/shuf_pkg.sv
// Shared defaults and types for the select-vector shuffle decoder pipeline.
// The config struct carries a rotation field wide enough for any lane count.
package shuf_pkg;

    localparam int LANES_DEF = 8;
    localparam int SELW_DEF  = 3;
    localparam int CNT_W     = 16;
    localparam int ROT_W     = 8;

    typedef struct packed {
        logic [ROT_W-1:0] rot;
        logic             inv;
    } cfg_t;

endpackage

// File: rtl/shuf_lane_dec.sv
// One lane of the select decoder: a one-hot (or one-cold) LW-bit vector
// marking which bit position k the lane field targets, given rotation rot.
module shuf_lane_dec #(
    parameter int SELW     = 3,
    parameter int LANE_IDX = 0
) (
    input  logic [SELW-1:0]      f,
    input  logic [SELW-1:0]      rot,
    input  logic                 inv,
    output logic [2**SELW-1:0]   sel
);

    localparam int              LW  = 2**SELW;
    localparam logic [SELW-1:0] IDX = SELW'(LANE_IDX % LW);

    // NOTE: default every always_comb output first so no path can infer a latch.
    always_comb begin
        sel = '0;
        for (int k = 0; k < LW; k++) begin
            sel[k] = (f == SELW'(IDX - SELW'(k) + rot)) ^ inv;
        end
    end

endmodule

// File: rtl/shuf_sel_pipe.sv
// Two-stage valid/ready pipeline: S1 captures lane fields and a config
// snapshot, S2 holds the decoded select vector; counts output handshakes.
module shuf_sel_pipe
    import shuf_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int SELW  = SELW_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [SELW-1:0]             cfg_rot,
    input  logic                        cfg_inv,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*(2**SELW)-1:0]  in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*(2**SELW)-1:0]  out_sel,
    output logic [CNT_W-1:0]            out_cnt
);

    localparam int LW = 2**SELW;
    localparam int DW = LANES*LW;

    cfg_t                     cfg_q;
    cfg_t                     s1_cfg;
    logic                     s1_valid;
    logic [LANES*SELW-1:0]    s1_f;
    logic [LANES*SELW-1:0]    fields;
    logic [DW-1:0]            dec_sel;
    logic                     s2_free;
    logic                     unused_bits;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_free);

    // Only the low SELW bits of each lane and of the stored rotation matter.
    assign unused_bits = ^{in_b, s1_cfg.rot};

    always_comb begin
        fields = '0;
        for (int i = 0; i < LANES; i++) begin
            fields[i*SELW +: SELW] = in_b[i*LW +: SELW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
        end else if (cfg_we) begin
            cfg_q <= '{rot: ROT_W'(cfg_rot), inv: cfg_inv};
        end
    end

    // The snapshot takes cfg_q before any same-cycle cfg_we update lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_cfg   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_f   <= fields;
                s1_cfg <= cfg_q;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        shuf_lane_dec #(
            .SELW     (SELW),
            .LANE_IDX (g)
        ) u_dec (
            .f   (s1_f[g*SELW +: SELW]),
            .rot (s1_cfg.rot[SELW-1:0]),
            .inv (s1_cfg.inv),
            .sel (dec_sel[g*LW +: LW])
        );
    end

    // NOTE: out_sel is reset and zeroed on bubbles because it must read 0 whenever out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            out_sel   <= s1_valid ? dec_sel : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (out_valid && out_ready) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shuf_sel_pipe.sv
// Self-checking bench for shuf_sel_pipe: vector table, scoreboard queue and
// hand-written sequences for backpressure, reset-in-flight and counter wrap.
module tb_shuf_sel_pipe;
    import shuf_pkg::*;

    localparam int LANES = 8;
    localparam int SELW  = 3;
    localparam int DW    = 64;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [SELW-1:0]   cfg_rot;
    logic              cfg_inv;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_sel;
    logic [CNT_W-1:0]  out_cnt;

    shuf_sel_pipe #(.LANES(LANES), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_rot   (cfg_rot),
        .cfg_inv   (cfg_inv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned  cyc = 0;
    always @(posedge clk) cyc++;

    int           checks = 0;
    int           failures = 0;
    logic [63:0]  sb[$];
    logic [2:0]   m_rot = '0;
    logic         m_inv = 1'b0;
    logic         hold_prev = 1'b0;
    logic [63:0]  hold_sel = '0;
    logic         stop_rand = 1'b0;

    typedef struct {
        logic [63:0] b;
        logic        we;
        logic [2:0]  rot;
        logic        inv;
        logic [63:0] exp_sel;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] b, input logic [2:0] rot, input logic inv);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < 8; k++) begin
                int f;
                int tgt;
                f   = int'(b[i*8 +: 3]);
                tgt = ((i % 8) - k + int'(rot) + 16) % 8;
                r[i*8+k] = (f == tgt) ^ inv;
            end
        end
        return r;
    endfunction

    // Output monitor: scoreboard compare, hold stability and idle-zero checks.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_sel", out_sel, hold_sel);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %h expected no item", out_sel);
                end else begin
                    logic [63:0] e_sel;
                    e_sel = sb.pop_front();
                    check("data", out_sel, e_sel);
                end
            end else if (!out_valid) begin
                check("idle_zero", out_sel, 64'd0);
            end
            hold_prev = out_valid && !out_ready;
            hold_sel  = out_sel;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_item(input logic [63:0] b, input logic [63:0] e_sel);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
        end else begin
            sb.push_back(e_sel);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [2:0] rot, input logic inv);
        cfg_we  = 1'b1;
        cfg_rot = rot;
        cfg_inv = inv;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        m_rot  = rot;
        m_inv  = inv;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int unsigned c0;

        tbl[0] = '{64'h0,                 1'b0, 3'd0, 1'b0, 64'h8040201008040201};
        tbl[1] = '{64'h0706050403020100,  1'b0, 3'd0, 1'b0, 64'h0101010101010101};
        tbl[2] = '{64'h0,                 1'b1, 3'd1, 1'b0, 64'h0180402010080402};
        tbl[3] = '{64'h0,                 1'b1, 3'd0, 1'b1, 64'h7FBFDFEFF7FBFDFE};
        tbl[4] = '{64'h0,                 1'b1, 3'd2, 1'b0, 64'h0201804020100804};
        tbl[5] = '{64'hF8F8F8F8F8F8F8F8,  1'b1, 3'd0, 1'b0, 64'h8040201008040201};

        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_rot   = '0;
        cfg_inv   = 1'b0;
        in_valid  = 1'b0;
        in_b      = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sel",   out_sel,        64'd0);
        check("rst_out_cnt",   64'(out_cnt),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: handshake edge to out_valid is two cycles.
        in_valid = 1'b1;
        in_b     = '0;
        @(negedge clk);
        check("lat_in_ready", 64'(in_ready), 64'd1);
        sb.push_back(64'h8040201008040201);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("latency", 64'(lat), 64'd2);
        drain();

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].we) set_cfg(tbl[i].rot, tbl[i].inv);
            send_item(tbl[i].b, tbl[i].exp_sel);
        end
        drain();

        // cfg_we in the handshake cycle only affects the following item.
        in_valid = 1'b1;
        in_b     = '0;
        cfg_we   = 1'b1;
        cfg_rot  = 3'd1;
        cfg_inv  = 1'b0;
        @(negedge clk);
        if (in_ready) sb.push_back(64'h8040201008040201);
        check("same_cycle_ready0", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        m_rot  = 3'd1;
        m_inv  = 1'b0;
        @(negedge clk);
        if (in_ready) sb.push_back(64'h0180402010080402);
        check("same_cycle_ready1", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Random data, random config changes and random backpressure.
        fork
            begin
                while (1) begin
                    @(posedge clk);
                    #1;
                    if (stop_rand) break;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            logic [63:0] b;
            if ($urandom_range(0, 3) == 0) set_cfg(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            b = {$urandom, $urandom};
            send_item(b, model(b, m_rot, m_inv));
        end
        stop_rand = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drain();

        // Reset with two items in flight under a non-default config.
        set_cfg(3'd3, 1'b1);
        out_ready = 1'b0;
        send_item(64'h0, 64'h0);
        send_item(64'h0, 64'h0);
        #2;
        rst = 1'b1;
        sb.delete();
        m_rot = '0;
        m_inv = 1'b0;
        #1;
        check("rstfly_out_valid", 64'(out_valid), 64'd0);
        check("rstfly_out_sel",   out_sel,        64'd0);
        check("rstfly_out_cnt",   64'(out_cnt),   64'd0);
        check("rstfly_in_ready",  64'(in_ready),  64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_item(64'h0, 64'h8040201008040201);
        drain();
        check("rstfly_cnt_after", 64'(out_cnt), 64'd1);

        // Backpressure: two items fill the pipe, the third waits.
        out_ready = 1'b0;
        send_item(64'h0,                64'h8040201008040201);
        send_item(64'h0706050403020100, 64'h0101010101010101);
        fork
            send_item(64'h0101010101010101, 64'h4020100804020180);
            begin
                @(negedge clk);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_out_cnt", 64'(out_cnt), 64'd4);

        // Counter wrap after 65536 handshakes, at full throughput.
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 65536; i++) begin
            send_item(64'h0, 64'h8040201008040201);
        end
        check("throughput_cycles", 64'(cyc - c0), 64'd65536);
        drain();
        check("wrap_cnt0", 64'(out_cnt), 64'd0);
        send_item(64'h0706050403020100, 64'h0101010101010101);
        drain();
        check("wrap_cnt1", 64'(out_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shuf_sel_pipe.md
SHUF_SEL_PIPE -- requirements
Module: shuf_sel_pipe

Interface
REQ-001 SHALL have parameter LANES, default 8: number of select lanes.
REQ-002 SHALL have parameter SELW, default 3: select field width per lane; lane width LW = 2**SELW; data width DW = LANES*LW.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cfg_we  in  1  loads cfg_rot/cfg_inv into the config register on the next rising edge.
REQ-006 cfg_rot  in  SELW  rotation offset added to each lane's decode target.
REQ-007 cfg_inv  in  1  1 = one-cold output (decode inverted).
REQ-008 in_valid  in  1  input item present.
REQ-009 in_ready  out  1  block can accept an item this cycle.
REQ-010 in_b  in  DW  lane i select field = in_b[i*LW +: SELW]; all other bits ignored.
REQ-011 out_valid  out  1  out_sel holds a valid item.
REQ-012 out_ready  in  1  downstream accepts out_sel this cycle.
REQ-013 out_sel  out  DW  decoded select vector.
REQ-014 out_cnt  out  16  count of completed output handshakes.

Function
REQ-015 Decode SHALL be out_sel[i*LW+k] = (f_i == (i - k + rot) mod LW) XOR inv, for lane i, bit k, lane field f_i, all arithmetic modulo LW (i taken mod LW when LANES > LW).
REQ-016 With rot=0, inv=0, LANES=8, SELW=3, decode SHALL equal the existing 64-bit fixed shuffle decoder bit-for-bit.
REQ-017 Input handshake SHALL occur when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-018 Pipeline SHALL be two registered stages: S1 captures lane fields plus config snapshot; S2 holds decoded out_sel.
REQ-019 Latency SHALL be 2 cycles from input handshake to out_valid with out_ready held high.
REQ-020 Throughput SHALL be one item per cycle while out_ready is high.
REQ-021 in_ready SHALL equal !S1_valid || (!S2_valid || out_ready) (S1 may advance), and SHALL be 0 while rst is high.
REQ-022 S1 SHALL advance into S2 when S1_valid && (!S2_valid || out_ready).
REQ-023 Items SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-024 out_sel and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 Each item SHALL use the config value in effect at its input handshake; cfg_we in the same cycle as the handshake affects only later items.
REQ-026 out_cnt SHALL increment by 1 per output handshake and wrap from 16'hFFFF to 0.
REQ-027 out_sel SHALL be 0 whenever out_valid is 0.

Reset
REQ-028 On rst high, immediately and asynchronously: S1/S2 valid = 0, out_valid = 0, out_sel = 0, out_cnt = 0, config rot = 0, config inv = 0.
REQ-029 Items in flight when rst asserts SHALL be discarded; the first item accepted after reset SHALL use the default config.

Structure
REQ-030 Package shuf_pkg SHALL hold the LANES/SELW defaults, the CNT_W=16 constant and the config struct type (rot, inv).
REQ-031 Per-lane combinational decoder SHALL be sub-module shuf_lane_dec (params SELW, LANE_IDX), instantiated LANES times by generate.

Verification
REQ-032 rot=0, inv=0, in_b=64'h0 -> out_sel=64'h8040201008040201 exactly 2 cycles after the handshake.
REQ-033 in_b=64'h0706050403020100, default config -> out_sel=64'h0101010101010101.
REQ-034 cfg_we with rot=1, then in_b=0 -> 64'h0180402010080402; then rot=0, inv=1, in_b=0 -> 64'h7FBFDFEFF7FBFDFE.
REQ-035 3 back-to-back items with out_ready=0 for 5 cycles -> in_ready=0 after 2 items are held; all 3 delivered in order once out_ready=1; out_cnt=3.
REQ-036 rst pulsed with 2 items in flight -> out_valid=0, out_sel=0, out_cnt=0 immediately; next item decodes with rot=0, inv=0.
REQ-037 65536 output handshakes from reset -> out_cnt=0; one more -> out_cnt=1.
